// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control unit and its ALU decoder
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_RA = 4'd3,
        ALU_OR = 4'd4, ALU_XOR = 4'd5, ALU_LS = 4'd6, ALU_RS = 4'd7,
        ALU_EQ = 4'd8, ALU_NEQ = 4'd9, ALU_LT = 4'd10, ALU_LTS = 4'd11,
        ALU_GE = 4'd12, ALU_GES = 4'd13
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R, S_EXEC_I,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
    } state_e;

    typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BR} alu_cls_e;

    localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_R = 7'h33, OP_I = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;

    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps instruction class, funct3 and funct7[5] to the ALU operation code
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_cls_e    cls_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    output alu_op_e     alu_op_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        if (cls_i == CLS_BR) begin
            case (funct3_i)
                3'b000:  alu_op_o = ALU_EQ;
                3'b001:  alu_op_o = ALU_NEQ;
                3'b100:  alu_op_o = ALU_LTS;
                3'b101:  alu_op_o = ALU_GES;
                3'b110:  alu_op_o = ALU_LT;
                3'b111:  alu_op_o = ALU_GE;
                default: alu_op_o = ALU_ADD;
            endcase
        end else if (cls_i != CLS_ADD) begin
            case (funct3_i)
                3'b000:  alu_op_o = (cls_i == CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op_o = ALU_LS;
                3'b010:  alu_op_o = ALU_LTS;
                3'b011:  alu_op_o = ALU_LT;
                3'b100:  alu_op_o = ALU_XOR;
                3'b101:  alu_op_o = funct7b5_i ? ALU_RA : ALU_RS;
                3'b110:  alu_op_o = ALU_OR;
                default: alu_op_o = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXECUTE/MEM/WB sequencer driving the multicycle RV32I datapath
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit RESET_TRAP_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_flag,
    output logic        ir_write,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_control,
    output logic        illegal
);

    state_e   state_q, state_d;
    logic     illegal_q, illegal_d;
    alu_cls_e cls;
    alu_op_e  dec_op;
    logic     unused_instr;

    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign cls = state_q == S_EXEC_R ? CLS_R :
                 state_q == S_EXEC_I ? CLS_I :
                 state_q == S_BRANCH ? CLS_BR : CLS_ADD;

    alu_decoder u_alu_decoder (
        .cls_i      (cls),
        .funct3_i   (instr[14:12]),
        .funct7b5_i (instr[30]),
        .alu_op_o   (dec_op)
    );

    assign alu_control = dec_op;
    assign illegal     = illegal_q;
    assign illegal_d   = (state_d == S_TRAP) || (illegal_q && (RESET_TRAP_CLEAR || state_d != S_FETCH));

    assign imm_src = instr[6:0] == OP_STORE  ? IMM_S :
                     instr[6:0] == OP_BRANCH ? IMM_B :
                     instr[6:0] == OP_JAL    ? IMM_J :
                     (instr[6:0] == OP_LUI || instr[6:0] == OP_AUIPC) ? IMM_U : IMM_I;

    // Strobes are gated by resetn so an asserted reset silences them in the same cycle
    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        if (resetn) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = SRCB_FOUR;
                        result_src = RES_ALU;
                        state_d    = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (instr[6:0])
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = instr[14:13] == 2'b01 ? S_TRAP : S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_AUIPC;
                        default:           state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    state_d   = instr[5] ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                    state_d  = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    state_d   = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    state_d   = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    pc_write  = alu_flag;
                    state_d   = S_FETCH;
                end
                S_JALR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_JAL;
                end
                S_JAL: begin
                    pc_write  = 1'b1;
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    state_d   = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a = SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ALUWB;
                end
                default: state_d = RESET_TRAP_CLEAR ? S_TRAP : S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle checks of the multicycle control sequencer
module tb_multicycle_ctrl;

    logic        clk = 1'b0, resetn = 1'b0, mem_ready = 1'b0, alu_flag = 1'b0;
    logic [31:0] instr = 32'h0000_0013;
    logic        ir_write, pc_write, adr_src, mem_read, mem_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic [16:0] obs;
    int          vectors = 0, miscompares = 0;
    logic [16:0] fetch_rdy, fetch_wait, decode, aluwb, memadr, trap;

    multicycle_ctrl dut (
        .clk(clk), .resetn(resetn), .instr(instr), .mem_ready(mem_ready), .alu_flag(alu_flag),
        .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {ir_write, pc_write, adr_src, mem_read, mem_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_control, illegal};

    function automatic logic [16:0] mk(int iw, int pw, int as, int mr, int mw, int rw,
                                       int rs, int sa, int sb, int ac, int il);
        logic [31:0] v [11];
        v = '{iw, pw, as, mr, mw, rw, rs, sa, sb, ac, il};
        return {v[0][0], v[1][0], v[2][0], v[3][0], v[4][0], v[5][0],
                v[6][1:0], v[7][1:0], v[8][1:0], v[9][3:0], v[10][0]};
    endfunction

    task automatic test_reset;
        resetn = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (obs !== 17'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", obs, 17'd0); end
        @(negedge clk);
        resetn = 1'b1;
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (obs !== fetch_wait) begin miscompares++; $display("FAIL reset_fetch: got %h want %h", obs, fetch_wait); end
        @(posedge clk); #1;
        vectors++;
        if (obs !== fetch_wait) begin miscompares++; $display("FAIL fetch_hold: got %h want %h", obs, fetch_wait); end
    endtask

    task automatic test_imm_src;
        logic [31:0] ins [5];
        logic [2:0]  ex [5];
        ins = '{32'h0020A023, 32'h00208463, 32'h0000006F, 32'h000000B7, 32'h0000A083};
        ex = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr = ins[i];
            #1;
            vectors++;
            if (imm_src !== ex[i]) begin miscompares++; $display("FAIL imm_src[%0d]: got %0d want %0d", i, imm_src, ex[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        logic [16:0] e [5];
        e = '{fetch_rdy, decode, mk(0,0,0,0,0,0,0,2,0,0,0), aluwb, fetch_wait};
        instr = 32'h002081B3;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 4);
            #1;
            vectors++;
            if (obs !== e[i]) begin miscompares++; $display("FAIL add[%0d]: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_i;
        logic [31:0] ins [2];
        int          ac [2];
        logic [16:0] e;
        ins = '{32'h4030D093, 32'hFFF08093};
        ac = '{3, 0};
        for (int k = 0; k < 2; k++) begin
            instr = ins[k];
            for (int i = 0; i < 5; i++) begin
                e = i == 0 ? fetch_rdy : i == 1 ? decode : i == 2 ? mk(0,0,0,0,0,0,0,2,1,ac[k],0) :
                    i == 3 ? aluwb : fetch_wait;
                mem_ready = (i < 4);
                #1;
                vectors++;
                if (obs !== e) begin miscompares++; $display("FAIL alu_i%0d[%0d]: got %h want %h", k, i, obs, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load_wait;
        logic [16:0] e [9];
        int          r [9];
        logic [16:0] memrd;
        memrd = mk(0,0,1,1,0,0,0,0,0,0,0);
        e = '{fetch_rdy, decode, memadr, memrd, memrd, memrd, memrd, mk(0,0,0,0,0,1,1,0,0,0,0), fetch_wait};
        r = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
        instr = 32'h0000A083;
        for (int i = 0; i < 9; i++) begin
            mem_ready = r[i][0];
            #1;
            vectors++;
            if (obs !== e[i]) begin miscompares++; $display("FAIL load[%0d]: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch;
        logic [31:0] ins [3];
        int          fl [3], ac [3];
        logic [16:0] e;
        ins = '{32'h00208463, 32'h00208463, 32'h0020E463};
        fl = '{1, 0, 1};
        ac = '{8, 8, 10};
        for (int k = 0; k < 3; k++) begin
            instr = ins[k];
            alu_flag = fl[k][0];
            for (int i = 0; i < 4; i++) begin
                e = i == 0 ? fetch_rdy : i == 1 ? decode : i == 2 ? mk(0,fl[k],0,0,0,0,0,2,0,ac[k],0) : fetch_wait;
                mem_ready = (i < 3);
                #1;
                vectors++;
                if (obs !== e) begin miscompares++; $display("FAIL branch%0d[%0d]: got %h want %h", k, i, obs, e); end
                @(posedge clk); #1;
            end
        end
        alu_flag = 1'b0;
    endtask

    task automatic test_jal;
        logic [16:0] e [5];
        e = '{fetch_rdy, decode, mk(0,1,0,0,0,0,0,1,2,0,0), aluwb, fetch_wait};
        instr = 32'h0000006F;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 4);
            #1;
            vectors++;
            if (obs !== e[i]) begin miscompares++; $display("FAIL jal[%0d]: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_reset;
        logic [16:0] e [4];
        logic [16:0] memwr;
        memwr = mk(0,0,1,0,1,0,0,0,0,0,0);
        e = '{fetch_rdy, decode, memadr, memwr};
        instr = 32'h0020A023;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3);
            #1;
            vectors++;
            if (obs !== e[i]) begin miscompares++; $display("FAIL store[%0d]: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (obs !== memwr) begin miscompares++; $display("FAIL store_held: got %h want %h", obs, memwr); end
        resetn = 1'b0;
        #1;
        vectors++;
        if (obs !== 17'd0) begin miscompares++; $display("FAIL store_reset_abort: got %h want %h", obs, 17'd0); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (obs !== fetch_wait) begin miscompares++; $display("FAIL store_after_reset: got %h want %h", obs, fetch_wait); end
    endtask

    task automatic test_trap;
        logic [16:0] e;
        instr = 32'h0000000B;
        for (int i = 0; i < 22; i++) begin
            e = i == 0 ? fetch_rdy : i == 1 ? decode : trap;
            mem_ready = 1'b1;
            alu_flag = i[0];
            #1;
            vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL trap[%0d]: got %h want %h", i, obs, e); end
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (obs !== fetch_wait) begin miscompares++; $display("FAIL trap_cleared: got %h want %h", obs, fetch_wait); end
    endtask

    initial begin
        fetch_rdy  = mk(1,1,0,1,0,0,2,0,2,0,0);
        fetch_wait = mk(0,0,0,1,0,0,0,0,0,0,0);
        decode     = mk(0,0,0,0,0,0,0,1,1,0,0);
        aluwb      = mk(0,0,0,0,0,1,0,0,0,0,0);
        memadr     = mk(0,0,0,0,0,0,0,2,1,0,0);
        trap       = mk(0,0,0,0,0,0,0,0,0,0,1);
        test_reset();
        test_imm_src();
        test_add();
        test_alu_i();
        test_load_wait();
        test_branch();
        test_jal();
        test_store_reset();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
